// File: rtl/polygon_pkg.sv
// Shared types and constants for the polygon loader and its consumers.
package polygon_pkg;

  localparam int WORLD_BITS_DEFAULT       = 32;
  localparam int MAX_NUM_VERTICES_DEFAULT = 32;
  localparam int MIN_POLY_VERTICES        = 3;
  localparam int COUNT_BITS               = $clog2(MAX_NUM_VERTICES_DEFAULT + 1);

  typedef logic [COUNT_BITS-1:0] count_t;

  typedef enum logic [1:0] {
    FILL,
    PENDING,
    DROP
  } loader_state_t;

endpackage

// File: rtl/polygon_loader.sv
// Double-buffered polygon vertex loader: vertices stream into a back buffer,
// and a frame-boundary swap commits a completed polygon to the front buffer.
module polygon_loader
  import polygon_pkg::*;
#(
  parameter int WORLD_BITS       = WORLD_BITS_DEFAULT,
  parameter int MAX_NUM_VERTICES = MAX_NUM_VERTICES_DEFAULT
) (
  input  logic                                   clk_in,
  input  logic                                   rst_in,
  input  logic signed [WORLD_BITS-1:0]           vertex_x_in,
  input  logic signed [WORLD_BITS-1:0]           vertex_y_in,
  input  logic                                   vertex_valid_in,
  input  logic                                   vertex_last_in,
  output logic                                   vertex_ready_out,
  input  logic                                   swap_in,
  output logic signed [WORLD_BITS-1:0]           poly_xs_out [MAX_NUM_VERTICES],
  output logic signed [WORLD_BITS-1:0]           poly_ys_out [MAX_NUM_VERTICES],
  output logic [$clog2(MAX_NUM_VERTICES+1)-1:0]  num_points_out,
  output logic                                   poly_valid_out,
  output logic                                   error_out
);

  localparam int CNT_W = $clog2(MAX_NUM_VERTICES + 1);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_NUM_VERTICES);
  localparam logic [CNT_W:0]   MIN_TOTAL = (CNT_W+1)'(MIN_POLY_VERTICES);
  localparam logic [CNT_W:0]   MAX_TOTAL = (CNT_W+1)'(MAX_NUM_VERTICES);

  loader_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic signed [WORLD_BITS-1:0] back_x_q [MAX_NUM_VERTICES];
  logic signed [WORLD_BITS-1:0] back_x_d [MAX_NUM_VERTICES];
  logic signed [WORLD_BITS-1:0] back_y_q [MAX_NUM_VERTICES];
  logic signed [WORLD_BITS-1:0] back_y_d [MAX_NUM_VERTICES];
  logic signed [WORLD_BITS-1:0] front_x_q [MAX_NUM_VERTICES];
  logic signed [WORLD_BITS-1:0] front_x_d [MAX_NUM_VERTICES];
  logic signed [WORLD_BITS-1:0] front_y_q [MAX_NUM_VERTICES];
  logic signed [WORLD_BITS-1:0] front_y_d [MAX_NUM_VERTICES];
  logic [CNT_W-1:0] num_points_q, num_points_d;
  logic poly_valid_q, poly_valid_d;
  logic error_q, error_d;

  logic ready;
  logic accept;
  logic wr_en;
  logic [CNT_W:0] total;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    back_x_d     = back_x_q;
    back_y_d     = back_y_q;
    front_x_d    = front_x_q;
    front_y_d    = front_y_q;
    num_points_d = num_points_q;
    poly_valid_d = poly_valid_q;
    error_d      = error_q;
    wr_en        = 1'b0;
    ready        = (state_q != PENDING);
    accept       = vertex_valid_in && ready;
    total        = {1'b0, cnt_q} + (CNT_W+1)'(1);

    case (state_q)
      FILL: begin
        if (accept) begin
          if (vertex_last_in) begin
            if (total >= MIN_TOTAL && total <= MAX_TOTAL) begin
              wr_en   = 1'b1;
              cnt_d   = total[CNT_W-1:0];
              state_d = PENDING;
            end else begin
              error_d = 1'b1;
              cnt_d   = '0;
            end
          end else if (cnt_q == MAX_CNT) begin
            // Overflow: discard the rest of this polygon up to its last vertex.
            error_d = 1'b1;
            cnt_d   = '0;
            state_d = DROP;
          end else begin
            wr_en = 1'b1;
            cnt_d = total[CNT_W-1:0];
          end
        end
      end
      DROP: begin
        if (accept && vertex_last_in) begin
          state_d = FILL;
        end
      end
      PENDING: begin
        if (swap_in) begin
          front_x_d    = back_x_q;
          front_y_d    = back_y_q;
          num_points_d = cnt_q;
          poly_valid_d = 1'b1;
          cnt_d        = '0;
          state_d      = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
      if (wr_en && cnt_q == CNT_W'(i)) begin
        back_x_d[i] = vertex_x_in;
        back_y_d[i] = vertex_y_in;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      back_x_q     <= '{default: '0};
      back_y_q     <= '{default: '0};
      front_x_q    <= '{default: '0};
      front_y_q    <= '{default: '0};
      num_points_q <= '0;
      poly_valid_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      back_x_q     <= back_x_d;
      back_y_q     <= back_y_d;
      front_x_q    <= front_x_d;
      front_y_q    <= front_y_d;
      num_points_q <= num_points_d;
      poly_valid_q <= poly_valid_d;
      error_q      <= error_d;
    end
  end

  assign vertex_ready_out = (state_q != PENDING);
  assign poly_xs_out      = front_x_q;
  assign poly_ys_out      = front_y_q;
  assign num_points_out   = num_points_q;
  assign poly_valid_out   = poly_valid_q;
  assign error_out        = error_q;

endmodule

// File: tb/tb_polygon_loader.sv
// Self-checking bench for polygon_loader: expected polygons are queued as they
// are streamed and compared against the front buffer when a swap commits them.
module tb_polygon_loader;

  localparam int WB   = polygon_pkg::WORLD_BITS_DEFAULT;
  localparam int MAXV = polygon_pkg::MAX_NUM_VERTICES_DEFAULT;
  localparam int CW   = $clog2(MAXV + 1);

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic                 rst_in;
  logic signed [WB-1:0] vertex_x_in, vertex_y_in;
  logic                 vertex_valid_in, vertex_last_in, vertex_ready_out, swap_in;
  logic signed [WB-1:0] poly_xs_out [MAXV];
  logic signed [WB-1:0] poly_ys_out [MAXV];
  logic [CW-1:0]        num_points_out;
  logic                 poly_valid_out, error_out;

  polygon_loader dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .vertex_x_in     (vertex_x_in),
    .vertex_y_in     (vertex_y_in),
    .vertex_valid_in (vertex_valid_in),
    .vertex_last_in  (vertex_last_in),
    .vertex_ready_out(vertex_ready_out),
    .swap_in         (swap_in),
    .poly_xs_out     (poly_xs_out),
    .poly_ys_out     (poly_ys_out),
    .num_points_out  (num_points_out),
    .poly_valid_out  (poly_valid_out),
    .error_out       (error_out)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard of polygons expected to commit, in stream order.
  int                   exp_n_q [$];
  logic signed [WB-1:0] exp_x_q [$];
  logic signed [WB-1:0] exp_y_q [$];

  // Model of the front buffer.
  int                   front_n;
  bit                   front_valid;
  logic signed [WB-1:0] front_x [MAXV];
  logic signed [WB-1:0] front_y [MAXV];

  logic signed [WB-1:0] vx_tab [40];
  logic signed [WB-1:0] vy_tab [40];

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic fill_random(input int n);
    for (int k = 0; k < n; k++) begin
      vx_tab[k] = $urandom;
      vy_tab[k] = $urandom;
    end
  endtask

  task automatic apply_reset();
    rst_in = 1'b0;
    vertex_valid_in = 1'b0;
    vertex_last_in = 1'b0;
    swap_in = 1'b0;
    vertex_x_in = '0;
    vertex_y_in = '0;
    step();
    step();
    rst_in = 1'b1;
    exp_n_q.delete();
    exp_x_q.delete();
    exp_y_q.delete();
    front_n = 0;
    front_valid = 1'b0;
    for (int k = 0; k < MAXV; k++) begin
      front_x[k] = '0;
      front_y[k] = '0;
    end
  endtask

  // Streams n vertices back to back from the tables; pushes the polygon to the
  // scoreboard when its length is committable.
  task automatic send_poly(input int n, input bit swap_on_last, input string tag);
    int not_ready = 0;
    for (int k = 0; k < n; k++) begin
      vertex_valid_in = 1'b1;
      vertex_x_in = vx_tab[k];
      vertex_y_in = vy_tab[k];
      vertex_last_in = (k == n - 1);
      swap_in = swap_on_last && (k == n - 1);
      if (vertex_ready_out !== 1'b1) not_ready++;
      step();
    end
    vertex_valid_in = 1'b0;
    vertex_last_in = 1'b0;
    swap_in = 1'b0;
    n_checks++;
    if (not_ready != 0) $display("FAIL %s stream_ready got %0d stalls want 0", tag, not_ready);
    else n_pass++;
    if (n >= 3 && n <= MAXV) begin
      exp_n_q.push_back(n);
      for (int k = 0; k < n; k++) begin
        exp_x_q.push_back(vx_tab[k]);
        exp_y_q.push_back(vy_tab[k]);
      end
    end
  endtask

  // Pulses swap; a commit pops the scoreboard into the front model, then the
  // front outputs are compared with the model either way.
  task automatic do_swap(input bit expect_commit, input string tag);
    int bad = 0;
    if (expect_commit) begin
      n_checks++;
      if (vertex_ready_out !== 1'b0) $display("FAIL %s pending_ready got %0b want 0", tag, vertex_ready_out);
      else n_pass++;
    end
    swap_in = 1'b1;
    step();
    swap_in = 1'b0;
    if (expect_commit) begin
      n_checks++;
      if (exp_n_q.size() == 0) begin
        $display("FAIL %s scoreboard got empty want one polygon", tag);
      end else begin
        n_pass++;
        front_n = exp_n_q.pop_front();
        front_valid = 1'b1;
        for (int k = 0; k < front_n; k++) begin
          front_x[k] = exp_x_q.pop_front();
          front_y[k] = exp_y_q.pop_front();
        end
      end
    end
    n_checks++;
    if (num_points_out !== CW'(front_n)) $display("FAIL %s num_points got %0d want %0d", tag, num_points_out, front_n);
    else n_pass++;
    n_checks++;
    if (poly_valid_out !== front_valid) $display("FAIL %s poly_valid got %0b want %0b", tag, poly_valid_out, front_valid);
    else n_pass++;
    n_checks++;
    if (vertex_ready_out !== 1'b1) $display("FAIL %s ready_after_swap got %0b want 1", tag, vertex_ready_out);
    else n_pass++;
    for (int k = 0; k < front_n; k++)
      if (poly_xs_out[k] !== front_x[k] || poly_ys_out[k] !== front_y[k]) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL %s front_arrays got %0d wrong entries want 0", tag, bad);
    else n_pass++;
    $display("swap %s: commit=%0b num_points=%0d valid=%0b error=%0b",
             tag, expect_commit, num_points_out, poly_valid_out, error_out);
  endtask

  task automatic test_reset();
    int nz = 0;
    apply_reset();
    for (int k = 0; k < MAXV; k++)
      if (poly_xs_out[k] !== '0 || poly_ys_out[k] !== '0) nz++;
    n_checks++;
    if (vertex_ready_out !== 1'b1) $display("FAIL reset ready got %0b want 1", vertex_ready_out);
    else n_pass++;
    n_checks++;
    if (num_points_out !== '0 || poly_valid_out !== 1'b0 || error_out !== 1'b0)
      $display("FAIL reset outputs got num=%0d valid=%0b err=%0b want 0/0/0",
               num_points_out, poly_valid_out, error_out);
    else n_pass++;
    n_checks++;
    if (nz != 0) $display("FAIL reset arrays got %0d nonzero want 0", nz);
    else n_pass++;
    $display("reset: ready=%0b num_points=%0d", vertex_ready_out, num_points_out);
  endtask

  task automatic test_square();
    vx_tab[0] = 0;  vy_tab[0] = 0;
    vx_tab[1] = 10; vy_tab[1] = 0;
    vx_tab[2] = 10; vy_tab[2] = 10;
    vx_tab[3] = 0;  vy_tab[3] = 10;
    send_poly(4, 1'b0, "square");
    step();
    n_checks++;
    if (vertex_ready_out !== 1'b0) $display("FAIL square ready_held got %0b want 0", vertex_ready_out);
    else n_pass++;
    do_swap(1'b1, "square");
    n_checks++;
    if (error_out !== 1'b0) $display("FAIL square error got %0b want 0", error_out);
    else n_pass++;
  endtask

  task automatic test_hold_pending();
    int bad = 0;
    fill_random(3);
    send_poly(3, 1'b0, "triA");
    do_swap(1'b1, "triA");
    fill_random(3);
    send_poly(3, 1'b0, "triB");
    vertex_valid_in = 1'b1;
    vertex_last_in = 1'b1;
    vertex_x_in = 32'sd777;
    vertex_y_in = -32'sd777;
    for (int c = 0; c < 3; c++) begin
      if (vertex_ready_out !== 1'b0 || num_points_out !== CW'(front_n) ||
          poly_xs_out[0] !== front_x[0]) bad++;
      step();
    end
    vertex_valid_in = 1'b0;
    vertex_last_in = 1'b0;
    n_checks++;
    if (bad != 0) $display("FAIL hold_pending got %0d bad cycles want 0", bad);
    else n_pass++;
    do_swap(1'b1, "triB");
  endtask

  task automatic test_full32();
    fill_random(MAXV);
    send_poly(MAXV, 1'b1, "full32");
    n_checks++;
    if (vertex_ready_out !== 1'b0 || num_points_out !== CW'(front_n))
      $display("FAIL full32 same_cycle_swap got ready=%0b num=%0d want 0/%0d",
               vertex_ready_out, num_points_out, front_n);
    else n_pass++;
    do_swap(1'b1, "full32");
  endtask

  task automatic test_short();
    apply_reset();
    fill_random(2);
    send_poly(2, 1'b0, "short2");
    n_checks++;
    if (error_out !== 1'b1 || vertex_ready_out !== 1'b1)
      $display("FAIL short2 err_ready got err=%0b ready=%0b want 1/1", error_out, vertex_ready_out);
    else n_pass++;
    do_swap(1'b0, "short2");
  endtask

  task automatic test_overflow();
    apply_reset();
    fill_random(3);
    send_poly(3, 1'b0, "pre_ovf");
    do_swap(1'b1, "pre_ovf");
    fill_random(MAXV + 1);
    send_poly(MAXV + 1, 1'b0, "ovf33");
    n_checks++;
    if (error_out !== 1'b1) $display("FAIL ovf33 error got %0b want 1", error_out);
    else n_pass++;
    do_swap(1'b0, "ovf33");
    fill_random(MAXV + 4);
    send_poly(MAXV + 4, 1'b0, "drop36");
    do_swap(1'b0, "drop36");
    fill_random(3);
    send_poly(3, 1'b0, "post_ovf");
    do_swap(1'b1, "post_ovf");
  endtask

  task automatic test_reset_pending();
    int nz = 0;
    fill_random(3);
    send_poly(3, 1'b0, "lost");
    rst_in = 1'b0;
    swap_in = 1'b1;
    vertex_valid_in = 1'b1;
    vertex_last_in = 1'b1;
    step();
    rst_in = 1'b1;
    swap_in = 1'b0;
    vertex_valid_in = 1'b0;
    vertex_last_in = 1'b0;
    exp_n_q.delete();
    exp_x_q.delete();
    exp_y_q.delete();
    front_n = 0;
    front_valid = 1'b0;
    for (int k = 0; k < MAXV; k++)
      if (poly_xs_out[k] !== '0 || poly_ys_out[k] !== '0) nz++;
    n_checks++;
    if (num_points_out !== '0 || poly_valid_out !== 1'b0 || error_out !== 1'b0 ||
        vertex_ready_out !== 1'b1 || nz != 0)
      $display("FAIL rst_pending got num=%0d valid=%0b err=%0b ready=%0b nz=%0d want 0/0/0/1/0",
               num_points_out, poly_valid_out, error_out, vertex_ready_out, nz);
    else n_pass++;
    do_swap(1'b0, "post_rst");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_in = 1'b0;
    step();
    test_reset();
    test_square();
    test_hold_pending();
    test_full32();
    test_short();
    test_overflow();
    test_reset_pending();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
